// File: rtl/ir_frame_decoder.sv
// -----------------------------------------------------------------------------
// ir_frame_decoder
//
// Pulse-width IR frame receiver. A frame is a start pulse (4T low) followed by
// LSB-first data bits, each a low pulse (1T = '0', 2T = '1') followed by a 1T
// high pause. A pause longer than 2*T_MAX ends the frame. Frames whose length
// is enabled in ACCEPT_LEN_MASK are handed downstream over valid/ready. A frame
// equal to the previously delivered one, arriving within REPEAT_GAP cycles, is
// flagged as a repeat. Malformed frames raise a one-cycle err pulse. A good
// frame that cannot be handed over raises a one-cycle overrun pulse.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   ir           raw IR input, active-low, asynchronous to clk
//   frame_data   received bits, bit i = i-th bit received, unused bits 0
//   frame_nbits  number of valid bits in frame_data
//   frame_repeat frame equals the previous good frame and arrived within the gap
//   frame_valid  frame_* fields valid, held until frame_ready
//   frame_ready  consumer accepts the frame when frame_valid && frame_ready
//   err          one-cycle pulse: malformed frame aborted
//   overrun      one-cycle pulse: good frame dropped, output still occupied
// -----------------------------------------------------------------------------
module ir_frame_decoder #(
  parameter int          BASE_PULSE_WIDTH = 30000,
  parameter real         ERROR_MARGIN     = 0.1,
  parameter int          MAX_BITS         = 20,
  parameter logic [31:0] ACCEPT_LEN_MASK  = 32'h0010_9000,
  parameter int          REPEAT_GAP       = 60 * BASE_PULSE_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ir,
  output logic [MAX_BITS-1:0] frame_data,
  output logic [4:0]          frame_nbits,
  output logic                frame_repeat,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                err,
  output logic                overrun
);

  // Tolerance window for one nominal pulse width.
  localparam int T_MIN    = $rtoi(BASE_PULSE_WIDTH * (1.0 - ERROR_MARGIN));
  localparam int T_MAX    = $rtoi(BASE_PULSE_WIDTH * (1.0 + ERROR_MARGIN));
  localparam int CNT_SPAN = (8 * T_MAX > REPEAT_GAP) ? 8 * T_MAX : REPEAT_GAP;
  localparam int CNT_W    = $clog2(CNT_SPAN + 1);
  localparam int GAP_W    = $clog2(REPEAT_GAP + 2);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [GAP_W-1:0] gap_t;

  localparam cnt_t ONE_MIN   = cnt_t'(T_MIN);
  localparam cnt_t ONE_MAX   = cnt_t'(T_MAX);
  localparam cnt_t TWO_MIN   = cnt_t'(2 * T_MIN);
  localparam cnt_t TWO_MAX   = cnt_t'(2 * T_MAX);
  localparam cnt_t START_MIN = cnt_t'(4 * T_MIN);
  localparam cnt_t START_MAX = cnt_t'(4 * T_MAX);
  localparam gap_t GAP_LIMIT = gap_t'(REPEAT_GAP);
  localparam gap_t GAP_SAT   = gap_t'(REPEAT_GAP + 1);
  localparam logic [4:0] FULL_BITS = 5'(MAX_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PAUSE,
    S_BIT,
    S_WAIT_HIGH
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Reset to the idle (high) level so that leaving reset
  // never looks like the beginning of a start pulse.
  // ---------------------------------------------------------------------------
  logic ir_meta_q;
  logic irs_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the
    // two synchroniser stages into one.
    if (rst) begin
      ir_meta_q <= 1'b1;
      irs_q     <= 1'b1;
    end else begin
      ir_meta_q <= ir;
      irs_q     <= ir_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  cnt_t                cnt_q, cnt_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [MAX_BITS-1:0] shift_q, shift_d;
  gap_t                gap_q, gap_d;
  logic                last_valid_q, last_valid_d;
  logic [MAX_BITS-1:0] last_data_q, last_data_d;
  logic [4:0]          last_nbits_q, last_nbits_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic [4:0]          nbits_q, nbits_d;
  logic                repeat_q, repeat_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                overrun_q, overrun_d;

  // Events produced by the next-state logic and consumed by the datapath.
  logic cnt_clr;
  logic cnt_inc;
  logic frame_clr;
  logic bit_store;
  logic bit_val;
  logic err_ev;
  logic end_ev;

  // Saturating increment: the counter never wraps back into a valid window.
  cnt_t cnt_nxt;
  assign cnt_nxt = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic and timing decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    frame_clr = 1'b0;
    bit_store = 1'b0;
    bit_val   = 1'b0;
    err_ev    = 1'b0;
    end_ev    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!irs_q) begin
          state_d   = S_START;
          cnt_clr   = 1'b1;
          frame_clr = 1'b1;
        end
      end

      S_START: begin
        if (!irs_q) begin
          cnt_inc = 1'b1;
          // Start held far too long: give up and wait for the line to recover.
          if (cnt_nxt > START_MAX) begin
            err_ev  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else if (cnt_q >= START_MIN && cnt_q <= START_MAX) begin
          state_d = S_PAUSE;
          cnt_clr = 1'b1;
        end else begin
          err_ev  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_PAUSE: begin
        if (irs_q) begin
          cnt_inc = 1'b1;
          // A long high level is the frame terminator.
          if (cnt_nxt > TWO_MAX) begin
            end_ev  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (cnt_q >= ONE_MIN && cnt_q <= ONE_MAX) begin
          if (bit_cnt_q == FULL_BITS) begin
            err_ev  = 1'b1;
            state_d = S_WAIT_HIGH;
          end else begin
            state_d = S_BIT;
            cnt_clr = 1'b1;
          end
        end else begin
          err_ev  = 1'b1;
          state_d = S_WAIT_HIGH;
        end
      end

      S_BIT: begin
        if (!irs_q) begin
          cnt_inc = 1'b1;
          if (cnt_nxt > TWO_MAX) begin
            err_ev  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else if (cnt_q >= ONE_MIN && cnt_q <= ONE_MAX) begin
          bit_store = 1'b1;
          bit_val   = 1'b0;
          state_d   = S_PAUSE;
          cnt_clr   = 1'b1;
        end else if (cnt_q >= TWO_MIN && cnt_q <= TWO_MAX) begin
          bit_store = 1'b1;
          bit_val   = 1'b1;
          state_d   = S_PAUSE;
          cnt_clr   = 1'b1;
        end else begin
          err_ev  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_WAIT_HIGH: begin
        if (irs_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: datapath and output next-state
  // ---------------------------------------------------------------------------
  logic len_ok;
  logic good_end;
  logic is_repeat;
  logic load;
  logic gap_run;

  assign len_ok    = ACCEPT_LEN_MASK[bit_cnt_q];
  assign good_end  = end_ev && len_ok;
  assign is_repeat = last_valid_q && (last_data_q == shift_q) &&
                     (last_nbits_q == bit_cnt_q) && (gap_q <= GAP_LIMIT);
  // A frame may load into a slot that is being emptied in the same cycle.
  assign load      = good_end && (!valid_q || frame_ready);
  // The gap clock is frozen while a frame is being received.
  assign gap_run   = (state_q == S_IDLE) || (state_q == S_WAIT_HIGH);

  always_comb begin
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    gap_d        = gap_q;
    last_valid_d = last_valid_q;
    last_data_d  = last_data_q;
    last_nbits_d = last_nbits_q;
    data_d       = data_q;
    nbits_d      = nbits_q;
    repeat_d     = repeat_q;
    valid_d      = valid_q;
    overrun_d    = 1'b0;
    err_d        = err_ev || (end_ev && !len_ok);

    if (cnt_clr)      cnt_d = '0;
    else if (cnt_inc) cnt_d = cnt_nxt;

    if (frame_clr) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (bit_store) begin
      for (int i = 0; i < MAX_BITS; i++) begin
        if (bit_cnt_q == 5'(i)) shift_d[i] = bit_val;
      end
      bit_cnt_d = bit_cnt_q + 5'd1;
    end

    if (good_end)                        gap_d = '0;
    else if (gap_run && gap_q != GAP_SAT) gap_d = gap_q + 1'b1;

    if (valid_q && frame_ready) valid_d = 1'b0;

    if (good_end) begin
      // The record tracks every good frame, including ones that get dropped.
      last_valid_d = 1'b1;
      last_data_d  = shift_q;
      last_nbits_d = bit_cnt_q;
      if (load) begin
        data_d   = shift_q;
        nbits_d  = bit_cnt_q;
        repeat_d = is_repeat;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      gap_q        <= '0;
      // NOTE: the last-frame record is cleared on reset as well, even though
      // last_valid_q alone guards it, so post-reset behaviour never depends on
      // stale contents.
      last_valid_q <= 1'b0;
      last_data_q  <= '0;
      last_nbits_q <= '0;
      data_q       <= '0;
      nbits_q      <= '0;
      repeat_q     <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      gap_q        <= gap_d;
      last_valid_q <= last_valid_d;
      last_data_q  <= last_data_d;
      last_nbits_q <= last_nbits_d;
      data_q       <= data_d;
      nbits_q      <= nbits_d;
      repeat_q     <= repeat_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign frame_data   = data_q;
  assign frame_nbits  = nbits_q;
  assign frame_repeat = repeat_q;
  assign frame_valid  = valid_q;
  assign err          = err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_ir_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_ir_frame_decoder
//
// Directed and randomized bench for ir_frame_decoder with T=10, margin 0.1
// (accepted pulse windows 9..11 / 18..22 / 36..44) and REPEAT_GAP=600.
// Frames are described by data and length; the reference model decides from
// the frame-format rules whether a frame is good and whether it is a repeat.
// -----------------------------------------------------------------------------
module tb_ir_frame_decoder;

  localparam int          T    = 10;
  localparam int          MAXB = 20;
  localparam logic [31:0] MASK = 32'h0010_9000;

  logic            clk = 1'b0;
  logic            rst;
  logic            ir;
  logic            frame_ready;
  logic [MAXB-1:0] frame_data;
  logic [4:0]      frame_nbits;
  logic            frame_repeat;
  logic            frame_valid;
  logic            err;
  logic            overrun;

  always #5 clk = ~clk;

  ir_frame_decoder #(
    .BASE_PULSE_WIDTH (T),
    .ERROR_MARGIN     (0.1),
    .MAX_BITS         (MAXB),
    .ACCEPT_LEN_MASK  (MASK),
    .REPEAT_GAP       (600)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ir           (ir),
    .frame_data   (frame_data),
    .frame_nbits  (frame_nbits),
    .frame_repeat (frame_repeat),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .err          (err),
    .overrun      (overrun)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Output monitor (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic            rep;
    logic [4:0]      nb;
    logic [MAXB-1:0] data;
  } obs_t;

  obs_t obs_q[$];
  obs_t mon_o;
  int   err_seen     = 0;
  int   ovr_seen     = 0;
  int   both_seen    = 0;
  int   valid_cycles = 0;

  always @(negedge clk) begin
    if (frame_valid && frame_ready) begin
      mon_o.rep  = frame_repeat;
      mon_o.nb   = frame_nbits;
      mon_o.data = frame_data;
      obs_q.push_back(mon_o);
    end
    if (frame_valid)    valid_cycles++;
    if (err)            err_seen++;
    if (overrun)        ovr_seen++;
    if (err && overrun) both_seen++;
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [31:0] accept_mask;
  int          exp_err   = 0;
  int          exp_ovr   = 0;
  bit          last_ok   = 1'b0;
  logic [31:0] last_data = '0;
  int          last_nb   = 0;
  bit          clean     = 1'b1;  // no malformed frame since the last good one

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit frame_good(input int nbits);
    return (nbits >= 1) && (nbits <= MAXB) && accept_mask[nbits];
  endfunction

  // Idle before a frame is gap + 40 cycles of high level. About 26 of those
  // elapse before the previous frame is recognised as ended, so <=500 idle is
  // comfortably inside the 600-cycle window and >=700 comfortably outside.
  function automatic bit exp_repeat(input logic [31:0] data, input int nbits, input int gap);
    return last_ok && clean && (last_nb == nbits) && (last_data == data) && (gap + 40 <= 500);
  endfunction

  function automatic void record_good(input logic [31:0] data, input int nbits);
    last_ok   = 1'b1;
    last_data = data;
    last_nb   = nbits;
    clean     = 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic lvl, input int n);
    ir = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int jit(input bit en);
    return en ? int'($urandom_range(0, 1)) : 0;
  endfunction

  // Ends with the last data bit's low pulse just finished; ir is left low.
  task automatic send_frame(input logic [31:0] data, input int nbits, input bit j);
    drive(1'b0, 4 * T + jit(j));
    for (int i = 0; i < nbits; i++) begin
      drive(1'b1, T + jit(j));
      drive(1'b0, (data[i] ? 2 * T : T) + jit(j));
    end
  endtask

  task automatic step(input string tag, input logic [31:0] data, input int nbits,
                      input int gap, input bit j);
    bit   rep;
    obs_t o;
    drive(1'b1, gap);
    send_frame(data, nbits, j);
    drive(1'b1, 40);
    if (frame_good(nbits)) begin
      rep = exp_repeat(data, nbits, gap);
      record_good(data, nbits);
      if (frame_ready) begin
        check({tag, " delivered"}, obs_q.size(), 1);
        if (obs_q.size() > 0) begin
          o = obs_q.pop_front();
          check({tag, " data"},   o.data, data);
          check({tag, " nbits"},  o.nb, nbits);
          check({tag, " repeat"}, o.rep, rep);
        end
      end
    end else begin
      exp_err++;
      clean = 1'b0;
      if (frame_ready) check({tag, " delivered"}, obs_q.size(), 0);
    end
    check({tag, " err count"}, err_seen, exp_err);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          vc0;
    int          e0;
    obs_t        o;
    logic [31:0] d;
    int          nb;
    int          gap;
    int          sel;

    accept_mask = MASK;
    rst         = 1'b1;
    ir          = 1'b1;
    frame_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset valid",   frame_valid, 0);
    check("reset data",    frame_data, 0);
    check("reset nbits",   frame_nbits, 0);
    check("reset repeat",  frame_repeat, 0);
    check("reset err",     err, 0);
    check("reset overrun", overrun, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1. nominal 12-bit frame, valid for exactly one cycle with ready high
    vc0 = valid_cycles;
    step("t1", 32'h095, 12, 100, 1'b0);
    check("t1 valid cycles", valid_cycles - vc0, 1);

    // 2. repeat detection
    step("t2 near",  32'h095, 12, 160, 1'b0);
    step("t2 far",   32'h095, 12, 960, 1'b0);
    step("t2 other", 32'h096, 12, 160, 1'b0);

    // 3. length boundaries
    step("t3 20b",   32'hABCDE, 20, 100, 1'b0);
    step("t3 13b",   32'h1A5A, 13, 100, 1'b0);
    step("t3 21b",   32'h1F0F0F, 21, 100, 1'b0);
    step("t3 0b",    32'h0, 0, 100, 1'b0);
    step("t3 15b",   32'h4321, 15, 100, 1'b1);

    // 4. back-pressure: hold, overrun, then load on the consume cycle
    frame_ready = 1'b0;
    step("t4 a", 32'h0A1, 12, 100, 1'b0);
    check("t4 held valid", frame_valid, 1);
    check("t4 held data",  frame_data, 32'h0A1);
    step("t4 b", 32'h0B2, 12, 60, 1'b0);
    exp_ovr++;
    check("t4 overrun",   ovr_seen, exp_ovr);
    check("t4 kept data", frame_data, 32'h0A1);
    check("t4 kept nbits", frame_nbits, 12);
    // Third frame equals the dropped one. The frame end is decided 2 sync
    // cycles + 1 entry cycle + (2*T_MAX+1) pause counts after ir rises, so
    // ready is raised only for the cycle ending at rising edge 26.
    drive(1'b1, 60);
    send_frame(32'h0B2, 12, 1'b0);
    ir = 1'b1;
    repeat (25) begin
      @(posedge clk);
      #1;
    end
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    @(negedge clk);
    check("t4 c valid",   frame_valid, 1);
    check("t4 c data",    frame_data, 32'h0B2);
    check("t4 c repeat",  frame_repeat, 1);
    check("t4 no overrun", ovr_seen, exp_ovr);
    check("t4 a consumed", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check("t4 a data", o.data, 32'h0A1);
    end
    record_good(32'h0B2, 12);
    frame_ready = 1'b1;
    drive(1'b1, 40);
    check("t4 c delivered", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check("t4 c popped data", o.data, 32'h0B2);
    end

    // 5. timing errors, each followed by a good frame
    drive(1'b1, 100);
    drive(1'b0, 35);
    drive(1'b1, 40);
    exp_err++;
    clean = 1'b0;
    check("t5 short start", err_seen, exp_err);
    step("t5 after1", 32'h3A5, 12, 60, 1'b0);

    drive(1'b1, 60);
    drive(1'b0, 40);
    drive(1'b1, 10);
    drive(1'b0, 15);
    drive(1'b1, 40);
    exp_err++;
    clean = 1'b0;
    check("t5 bad bit", err_seen, exp_err);
    step("t5 after2", 32'h5C3, 12, 60, 1'b0);

    drive(1'b1, 60);
    drive(1'b0, 45);
    check("t5 long start early", err_seen, exp_err);
    drive(1'b0, 5);
    exp_err++;
    clean = 1'b0;
    check("t5 long start err", err_seen, exp_err);
    drive(1'b1, 40);
    check("t5 release no err", err_seen, exp_err);
    step("t5 after3", 32'h6E1, 12, 60, 1'b0);

    drive(1'b1, 60);
    drive(1'b0, 40);
    drive(1'b1, 8);
    drive(1'b0, 10);
    drive(1'b1, 40);
    exp_err++;
    clean = 1'b0;
    check("t5 short pause", err_seen, exp_err);
    step("t5 after4", 32'h7F0, 12, 60, 1'b0);

    // 6. reset mid-bit
    frame_ready = 1'b0;
    step("t6 held", 32'h123, 12, 60, 1'b0);
    check("t6 held valid", frame_valid, 1);
    e0 = err_seen;
    drive(1'b1, 60);
    drive(1'b0, 40);
    drive(1'b1, 10);
    drive(1'b0, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t6 rst valid", frame_valid, 0);
    check("t6 rst data",  frame_data, 0);
    check("t6 rst nbits", frame_nbits, 0);
    check("t6 rst err",   err, 0);
    ir = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    last_ok = 1'b0;
    drive(1'b1, 40);
    check("t6 no err", err_seen, e0);
    frame_ready = 1'b1;
    step("t6 after", 32'h123, 12, 60, 1'b0);

    // Randomized frames with jittered timing
    for (int k = 0; k < 25; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 2) begin
        nb = int'($urandom_range(0, 21));
      end else begin
        case ($urandom_range(0, 2))
          0:       nb = 12;
          1:       nb = 15;
          default: nb = 20;
        endcase
      end
      d = $urandom & ((32'd1 << nb) - 32'd1);
      if (sel >= 7 && last_ok) begin
        nb = last_nb;
        d  = last_data;
      end
      if (!clean && last_ok && nb == last_nb && d == last_data) d = d ^ 32'd1;
      gap = $urandom_range(0, 1) ? int'($urandom_range(0, 400)) : int'($urandom_range(700, 800));
      step($sformatf("rnd%0d", k), d, nb, gap, 1'b1);
    end

    check("overrun total",        ovr_seen, exp_ovr);
    check("err/overrun overlap",  both_seen, 0);
    check("no stray deliveries",  obs_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
